// File: rtl/crc_frame_tx.sv
// ---------------------------------------------------------------------------
// crc_frame_tx
//   Framing stage in front of an 8-bit-parallel CRC-16 engine (seed 0xFFFF).
//   Payload bytes arrive on a valid/ready stream. Each accepted byte is sent
//   downstream and also fed to the engine in the same cycle. Frames shorter
//   than MIN_LEN are padded with 0x00, and then the engine result is appended
//   low byte first. A one-cycle crc_clr pulse re-seeds the engine between
//   frames.
//
// Parameters
//   MIN_LEN  minimum payload length including pad (0 or 1 disables padding)
//   CNT_W    byte-counter width, MIN_LEN must be below 2**CNT_W
//   CRC_XOR  final XOR applied to the engine value before it is emitted
//
// Ports
//   clk        clock, all logic on rising edge
//   rst        asynchronous active-low reset
//   in_data    payload byte
//   in_valid   payload byte valid
//   in_last    final payload byte of the frame
//   in_ready   payload byte accepted when in_valid & in_ready
//   out_data   framed byte (payload, pad, CRC lo, CRC hi)
//   out_valid  out_data valid
//   out_last   marks the CRC hi byte
//   out_ready  downstream accepts when out_valid & out_ready
//   crc_data   byte to the engine data input
//   crc_en     engine update strobe, combinational, one pulse per byte
//   crc_clr    registered one-cycle pulse that re-seeds the engine
//   crc_in     current engine value
// ---------------------------------------------------------------------------
module crc_frame_tx #(
    parameter int          MIN_LEN = 0,
    parameter int          CNT_W   = 8,
    parameter logic [15:0] CRC_XOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [7:0]  crc_data,
    output logic        crc_en,
    output logic        crc_clr,
    input  logic [15:0] crc_in
);

    typedef enum logic [2:0] {
        ST_PAYLOAD = 3'd0,
        ST_PAD     = 3'd1,
        ST_CRC_LO  = 3'd2,
        ST_CRC_HI  = 3'd3,
        ST_CLR     = 3'd4
    } state_t;

    // MIN_LEN widened by one bit so count+1 can be compared without wrap.
    localparam logic [CNT_W:0] MIN_LEN_C = (CNT_W + 1)'(MIN_LEN);

    state_t             state_r;
    state_t             state_n;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_n;
    logic [CNT_W:0]     count_inc_s;
    logic [7:0]         out_data_r;
    logic               out_valid_r;
    logic               out_last_r;
    logic               crc_clr_r;
    logic               clr_n;
    logic [15:0]        crc_hold_r;
    logic [15:0]        crc_final_s;

    logic               slot_free_s;
    logic               in_ready_s;
    logic               crc_en_s;
    logic [7:0]         crc_data_s;
    logic               load_s;
    logic [7:0]         load_data_s;
    logic               load_last_s;
    logic               hold_load_s;

    // Saturating byte count: stops at MIN_LEN, which is all the pad logic needs.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W:0] inc);
        logic [CNT_W-1:0] res;
        if (inc >= MIN_LEN_C) begin
            res = MIN_LEN_C[CNT_W-1:0];
        end else begin
            res = inc[CNT_W-1:0];
        end
        return res;
    endfunction

    assign slot_free_s = !out_valid_r || out_ready;
    assign count_inc_s = {1'b0, count_r} + {{CNT_W{1'b0}}, 1'b1};
    assign crc_final_s = crc_in ^ CRC_XOR;

    // Next-state, slot-load and engine-strobe decode.
    always_comb begin
        state_n     = state_r;
        count_n     = count_r;
        in_ready_s  = 1'b0;
        crc_en_s    = 1'b0;
        crc_data_s  = 8'h00;
        load_s      = 1'b0;
        load_data_s = 8'h00;
        load_last_s = 1'b0;
        hold_load_s = 1'b0;
        clr_n       = 1'b0;

        case (state_r)
            ST_PAYLOAD: begin
                in_ready_s = slot_free_s;
                if (in_valid && slot_free_s) begin
                    load_s      = 1'b1;
                    load_data_s = in_data;
                    crc_en_s    = 1'b1;
                    crc_data_s  = in_data;
                    count_n     = sat_inc(count_inc_s);
                    if (in_last) begin
                        if (count_inc_s < MIN_LEN_C) begin
                            state_n = ST_PAD;
                        end else begin
                            state_n = ST_CRC_LO;
                        end
                    end else begin
                        state_n = ST_PAYLOAD;
                    end
                end else begin
                    state_n = ST_PAYLOAD;
                end
            end

            ST_PAD: begin
                if (slot_free_s) begin
                    load_s      = 1'b1;
                    load_data_s = 8'h00;
                    crc_en_s    = 1'b1;
                    crc_data_s  = 8'h00;
                    count_n     = sat_inc(count_inc_s);
                    if (count_inc_s >= MIN_LEN_C) begin
                        state_n = ST_CRC_LO;
                    end else begin
                        state_n = ST_PAD;
                    end
                end else begin
                    state_n = ST_PAD;
                end
            end

            ST_CRC_LO: begin
                // The engine took its last update on the previous edge, so
                // crc_in is already final here.
                if (slot_free_s) begin
                    load_s      = 1'b1;
                    load_data_s = crc_final_s[7:0];
                    hold_load_s = 1'b1;
                    state_n     = ST_CRC_HI;
                end else begin
                    state_n = ST_CRC_LO;
                end
            end

            ST_CRC_HI: begin
                if (slot_free_s) begin
                    load_s      = 1'b1;
                    load_data_s = crc_hold_r[15:8];
                    load_last_s = 1'b1;
                    clr_n       = 1'b1;
                    state_n     = ST_CLR;
                end else begin
                    state_n = ST_CRC_HI;
                end
            end

            ST_CLR: begin
                // in_ready stays low here so the next frame's first byte
                // reaches a freshly seeded engine.
                count_n = {CNT_W{1'b0}};
                state_n = ST_PAYLOAD;
            end

            default: begin
                count_n = {CNT_W{1'b0}};
                state_n = ST_PAYLOAD;
            end
        endcase
    end

    // State, counter and CRC-clear pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_PAYLOAD;
            count_r   <= {CNT_W{1'b0}};
            crc_clr_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            count_r   <= count_n;
            crc_clr_r <= clr_n;
        end
    end

    // Captures the final CRC so the hi byte is unaffected by a later re-seed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_hold_r <= 16'h0000;
        end else if (hold_load_s) begin
            crc_hold_r <= crc_final_s;
        end else begin
            crc_hold_r <= crc_hold_r;
        end
    end

    // Single-entry output slot; a load and a pop in the same cycle keep it full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_r  <= 8'h00;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (load_s) begin
            out_data_r  <= load_data_s;
            out_valid_r <= 1'b1;
            out_last_r  <= load_last_s;
        end else if (out_ready) begin
            out_data_r  <= out_data_r;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_data_r  <= out_data_r;
            out_valid_r <= out_valid_r;
            out_last_r  <= out_last_r;
        end
    end

    // Handshake and strobe are combinational, so hold them low during reset.
    assign in_ready  = in_ready_s & rst;
    assign crc_en    = crc_en_s & rst;
    assign crc_data  = crc_data_s;
    assign crc_clr   = crc_clr_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;

endmodule
